// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file read port and streams each word with its index.
// Define REG_DUMP_SKIP_ZERO_EN to begin the walk at r1 instead of r0.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
  output logic              out_last
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [4:0] FIRST = 5'd1;
`else
  localparam logic [4:0] FIRST = 5'd0;
`endif
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        oidx_q, oidx_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rf_rd_data;
        oidx_d  = idx_q;
        last_d  = (idx_q == LAST);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over a same-cycle handshake: that word is dropped
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) && !abort;
  assign rf_rd_addr = idx_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_idx    = oidx_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: randomized dumps checked against a word-sequence model of the walk.
// Honours REG_DUMP_SKIP_ZERO_EN the same way the design does.
module tb_reg_dump_reader;
  localparam int NREG = 32;
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NWORDS = NREG - FIRST;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, out_valid, out_last;
  logic [4:0]  rf_rd_addr, out_idx;
  logic [31:0] rf_rd_data, out_data;
  logic [31:0] rf   [NREG];
  logic [31:0] snap [NREG];
  int          total = 0;
  int          bad = 0;

  assign rf_rd_data = rf[rf_rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready low 3 cycles on word 5
  task automatic dump(input int mode, input int abort_word,
                      input bit noise, input bit abort_launch);
    int n = 0;
    int cyc = 1;
    int lowcnt = 0;
    int dones = 0;
    int stalls = 0;
    int hs_cyc = 0;
    int k;
    bit prev_hold = 0;
    bit finished = 0;
    bit aborted = 0;
    bit was_done;
    bit rdy, ab, hs;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl;
    for (int i = 0; i < NREG; i++) begin
      rf[i] = (mode == 1) ? $urandom : 32'hA5A5_0000 + 32'(i);
      snap[i] = rf[i];
    end
    start = 1'b1;
    abort = abort_launch;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    while (!finished) begin
      if (cyc > 600) begin
        check("timeout", cyc, 0);
        break;
      end
      was_done = done;
      check("busy", busy, 1);
      if (done) begin
        dones++;
        check("done_words", n, NWORDS);
        check("done_cyc", cyc, 1 + 2 * NWORDS + stalls);
      end
      if (out_valid) begin
        if (prev_hold) begin
          check("hold_data", out_data, hd);
          check("hold_idx", out_idx, hi);
          check("hold_last", out_last, hl);
        end else begin
          k = (FIRST + n > NREG - 1) ? NREG - 1 : FIRST + n;
          check("idx", out_idx, k);
          check("data", out_data, snap[k]);
          check("last", out_last, k == NREG - 1);
          check("gap", cyc - hs_cyc, 2);
        end
        rf[out_idx] = $urandom;
      end else if (!done) begin
        check("addr", rf_rd_addr, FIRST + n);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = 1'b1;
          if (out_valid && out_idx == 5 && lowcnt < 3) begin
            rdy = 1'b0;
            lowcnt++;
          end
        end
      endcase
      ab = (abort_word >= 0) && out_valid && rdy && (FIRST + n == abort_word);
      hs = out_valid && rdy && !ab;
      if (hs) begin
        n++;
        hs_cyc = cyc;
      end
      if (out_valid && !rdy) stalls++;
      prev_hold = out_valid && !rdy;
      hd = out_data;
      hi = out_idx;
      hl = out_last;
      out_ready = rdy;
      abort = ab;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      abort = 1'b0;
      if (ab) begin
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        aborted = 1;
        finished = 1;
      end else if (was_done) begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("done_once", dones, 1);
        finished = 1;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (aborted) begin
      @(posedge clk);
      #1;
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end else begin
      check("words", n, NWORDS);
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", rf_rd_addr, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;

    dump(0, -1, 1'b0, 1'b0);
    dump(2, -1, 1'b0, 1'b0);
    dump(0, -1, 1'b1, 1'b0);
    dump(0, 10, 1'b0, 1'b0);
    dump(0, -1, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) dump(1, -1, 1'b1, 1'b0);
    dump(1, 20, 1'b0, 1'b0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("mid_valid", out_valid, 1);
    clr = 1'b0;
    #1;
    check("aclr_busy", busy, 0);
    check("aclr_done", done, 0);
    check("aclr_valid", out_valid, 0);
    check("aclr_data", out_data, 0);
    check("aclr_idx", out_idx, 0);
    check("aclr_last", out_last, 0);
    check("aclr_addr", rf_rd_addr, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("rel_busy", busy, 0);
    check("rel_valid", out_valid, 0);

    dump(0, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Read-side debug engine for the CPU's 32 × 32-bit architectural register file. On a start pulse it walks the register file's read port from low to high index, capturing each value and emitting it over a valid/ready stream with its index and a last flag. It sits beside the register file, shares a read port with it, and feeds the debug/host dump path.

## Interface
- NUM_REGS, 32, number of registers walked; index width is 5 bits.
- DATA_W, 32, register width.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low clear.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  cancel an active dump.
- busy  output  1  high in READ, SEND, DONE.
- done  output  1  one-cycle pulse after the last word is accepted.
- rf_rd_addr  output  5  register file read address; equals internal index.
- rf_rd_data  input  DATA_W  register file read data; combinational from rf_rd_addr.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_W  captured register value.
- out_idx  output  5  index of out_data.
- out_last  output  1  marks the final word of the dump.

## Operation
States:
- IDLE: start=1 -> idx<=FIRST, go to READ. start=0 -> stay in IDLE.
- READ: rf_rd_addr=idx. At the edge: out_data<=rf_rd_data, out_idx<=idx, out_last<=(idx==NUM_REGS-1), out_valid<=1, go to SEND.
- SEND: out_valid held high, and out_data, out_idx and out_last stay stable until the handshake (out_valid & out_ready at a rising edge). On the handshake, out_valid<=0. If out_last=1, go to DONE. Otherwise idx<=idx+1 and go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE.

Rules:
- FIRST is 0, or 1 when the macro in Configuration is defined.
- start in any state other than IDLE is ignored. No queuing.
- abort=1 in READ, SEND or DONE: next state is IDLE, out_valid<=0, no done pulse. abort outranks a simultaneous handshake, so that word counts as not delivered. abort in IDLE has no effect, and a simultaneous start still launches a dump.
- Data is passed through unmodified. r0 reads as whatever the register file returns, normally 0.
- idx never wraps past NUM_REGS-1; the last flag ends the walk before that.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, rf_rd_addr=0, state=IDLE. Asserting clr at any point forces these immediately, independent of clk.
- start sampled at edge 0 -> READ in cycle 1 -> first out_valid in cycle 2.
- Each word costs 2 cycles (READ + SEND) when out_ready is held at 1. Every extra cycle out_ready is low adds one cycle.
- Full 32-word dump with out_ready=1: word k is valid in cycle 2+2k, the last word in cycle 64, done in cycle 65, busy=0 from cycle 66.
- rf_rd_data is sampled only at the end of the READ cycle. Writes to the register file after that point do not change the word already captured.

## Configuration
- REG_DUMP_SKIP_ZERO_EN defined: FIRST=1. The dump emits 31 words, indices 1..31. out_last is still at index 31, and done is in cycle 63 with out_ready=1.
- REG_DUMP_SKIP_ZERO_EN undefined: FIRST=0, and the dump emits 32 words, indices 0..31.

## Test plan
- Reset: clr=0 mid-SEND -> all outputs go to 0 asynchronously. After release the block is in IDLE with busy=0.
- Full dump, out_ready=1, register file preloaded with reg[i]=0xA5A50000+i -> 32 words, out_idx 0..31 with matching data; out_last only on idx 31; done in cycle 65.
- Backpressure: out_ready low for 3 cycles on word 5 -> out_valid, out_data=0xA5A50005 and out_idx=5 held stable for those cycles; word 6 follows the handshake after 2 cycles.
- start pulsed during a busy dump -> ignored; exactly one done and 32 words.
- abort asserted in the same cycle as the word-10 handshake -> next cycle in IDLE, out_valid=0, no done. A following start restarts from index 0.
- REG_DUMP_SKIP_ZERO_EN defined -> first word has out_idx=1, 31 words total, done in cycle 63.
